id_ex_pipe: RTL and testbench

ID_EX_PIPE -- requirements
Module: id_ex_pipe

---
 rtl/cpu_pkg.sv | 75 +++++++
 rtl/hazard_detect.sv | 27 ++
 rtl/id_ex_pipe.sv | 171 +++++++++++++++++
 tb/tb_id_ex_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU encodings and control-vector layout
package cpu_pkg;

    localparam int CTRL_W = 18;

    // Bit positions inside the 18-bit decoded control vector
    localparam int CB_REG_WRITE   = 17;
    localparam int CB_MEM_TO_REG  = 16;
    localparam int CB_MEM_READ    = 15;
    localparam int CB_MEM_WRITE   = 14;
    localparam int CB_BRANCH      = 13;
    localparam int CB_JUMP        = 12;
    localparam int CB_JAL         = 11;
    localparam int CB_ALU_SRC     = 10;
    localparam int CB_REG_DST     = 9;
    localparam int CB_ZERO_EXTEND = 8;
    localparam int CB_LUI         = 7;
    localparam int CB_SLTIU       = 6;
    localparam int CB_ALU_OP_MSB  = 5;
    localparam int CB_ALU_OP_LSB  = 2;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_SLL = 4'b0101,
        ALU_SRL = 4'b0110,
        ALU_SUB = 4'b0111,
        ALU_SLT = 4'b1000,
        ALU_SRA = 4'b1001
    } alu_op_e;

    // Same bit order as the flat control vector, MSB first
    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jal;
        logic       alu_src;
        logic       reg_dst;
        logic       zero_extend;
        logic       lui_ctrl;
        logic       sltiu_ctrl;
        logic [3:0] alu_op;
        logic [1:0] pad;
    } ctrl_t;

    // How the EX register is loaded on the next edge
    typedef enum logic [1:0] {
        LOAD_BUBBLE  = 2'd0,
        LOAD_HOLD    = 2'd1,
        LOAD_CAPTURE = 2'd2
    } ex_load_e;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard comparison between EX and ID
module hazard_detect (
    input  logic       ex_valid_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_reg_dst_i,
    input  logic       id_mem_write_i,
    input  logic       id_branch_i,
    output logic       hazard_o
);

    logic ex_is_load;
    logic rs_match;
    logic rt_match;

    // rt only counts as a source for R-type, stores and branches
    always_comb begin
        ex_is_load = ex_valid_i & ex_mem_read_i & (ex_rt_i != 5'd0);
        rs_match   = (ex_rt_i == id_rs_i);
        rt_match   = (ex_rt_i == id_rt_i) & (id_reg_dst_i | id_mem_write_i | id_branch_i);
        hazard_o   = ex_is_load & id_valid_i & (rs_match | rt_match);
    end

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use stall and stall counter
module id_ex_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              id_valid_i,
    input  logic [17:0]       id_ctrl_i,
    input  logic [4:0]        id_shamt_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic [4:0]        id_rd_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic              ex_valid_o,
    output logic [17:0]       ex_ctrl_o,
    output logic [4:0]        ex_shamt_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [4:0]        ex_rs_o,
    output logic [4:0]        ex_rt_o,
    output logic [4:0]        ex_rd_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              ex_valid_q,   ex_valid_d;
    ctrl_t             ex_ctrl_q,    ex_ctrl_d;
    logic [4:0]        ex_shamt_q,   ex_shamt_d;
    logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DATA_W-1:0] ex_imm_q,     ex_imm_d;
    logic [DATA_W-1:0] ex_pc4_q,     ex_pc4_d;
    logic [4:0]        ex_rs_q,      ex_rs_d;
    logic [4:0]        ex_rt_q,      ex_rt_d;
    logic [4:0]        ex_rd_q,      ex_rd_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;

    logic              hazard;
    ex_load_e          load_sel;

    hazard_detect u_hazard_detect (
        .ex_valid_i     (ex_valid_q),
        .ex_mem_read_i  (ex_ctrl_q.mem_read),
        .ex_rt_i        (ex_rt_q),
        .id_valid_i     (id_valid_i),
        .id_rs_i        (id_rs_i),
        .id_rt_i        (id_rt_i),
        .id_reg_dst_i   (id_ctrl_i[CB_REG_DST]),
        .id_mem_write_i (id_ctrl_i[CB_MEM_WRITE]),
        .id_branch_i    (id_ctrl_i[CB_BRANCH]),
        .hazard_o       (hazard)
    );

    assign stall_o = hazard & ~flush_i & ~hold_i;

    // Pick the load action: flush beats hold beats hazard beats capture
    always_comb begin
        load_sel = LOAD_CAPTURE;
        if (flush_i) begin
            load_sel = LOAD_BUBBLE;
        end else if (hold_i) begin
            load_sel = LOAD_HOLD;
        end else if (hazard) begin
            load_sel = LOAD_BUBBLE;
        end
    end

    // Next-state for the EX register; an invalid ID slot never carries controls
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ex_ctrl_d    = ex_ctrl_q;
        ex_shamt_d   = ex_shamt_q;
        ex_rs_data_d = ex_rs_data_q;
        ex_rt_data_d = ex_rt_data_q;
        ex_imm_d     = ex_imm_q;
        ex_pc4_d     = ex_pc4_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_rd_d      = ex_rd_q;
        case (load_sel)
            LOAD_BUBBLE: begin
                ex_valid_d   = 1'b0;
                ex_ctrl_d    = '0;
                ex_shamt_d   = '0;
                ex_rs_data_d = '0;
                ex_rt_data_d = '0;
                ex_imm_d     = '0;
                ex_pc4_d     = '0;
                ex_rs_d      = '0;
                ex_rt_d      = '0;
                ex_rd_d      = '0;
            end
            LOAD_CAPTURE: begin
                ex_valid_d   = id_valid_i;
                ex_ctrl_d    = id_valid_i ? ctrl_t'(id_ctrl_i) : '0;
                ex_shamt_d   = id_shamt_i;
                ex_rs_data_d = id_rs_data_i;
                ex_rt_data_d = id_rt_data_i;
                ex_imm_d     = id_imm_i;
                ex_pc4_d     = id_pc4_i;
                ex_rs_d      = id_rs_i;
                ex_rt_d      = id_rt_i;
                ex_rd_d      = id_rd_i;
            end
            default: begin
            end
        endcase
    end

    // Stall counter saturates at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    // EX register and counter, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ex_valid_q   <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_shamt_q   <= '0;
            ex_rs_data_q <= '0;
            ex_rt_data_q <= '0;
            ex_imm_q     <= '0;
            ex_pc4_q     <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_shamt_q   <= ex_shamt_d;
            ex_rs_data_q <= ex_rs_data_d;
            ex_rt_data_q <= ex_rt_data_d;
            ex_imm_q     <= ex_imm_d;
            ex_pc4_q     <= ex_pc4_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign ex_valid_o   = ex_valid_q;
    assign ex_ctrl_o    = ex_ctrl_q;
    assign ex_shamt_o   = ex_shamt_q;
    assign ex_rs_data_o = ex_rs_data_q;
    assign ex_rt_data_o = ex_rt_data_q;
    assign ex_imm_o     = ex_imm_q;
    assign ex_pc4_o     = ex_pc4_q;
    assign ex_rs_o      = ex_rs_q;
    assign ex_rt_o      = ex_rt_q;
    assign ex_rd_o      = ex_rd_q;
    assign stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - self-checking bench for id_ex_pipe
module tb_id_ex_pipe;

    localparam int DW = 32;

    // Control words built from the documented bit order
    //                         RW MR MRd MW Br J Jal AS RD ZE LUI SLTIU ALU  pad
    localparam logic [17:0] C_LW   = 18'b1_1_1_0_0_0_0_1_0_0_0_0_0010_00;
    localparam logic [17:0] C_ADD  = 18'b1_0_0_0_0_0_0_0_1_0_0_0_0010_00;
    localparam logic [17:0] C_ADDI = 18'b1_0_0_0_0_0_0_1_0_0_0_0_0010_00;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          id_valid_i;
    logic [17:0]   id_ctrl_i;
    logic [4:0]    id_shamt_i;
    logic [DW-1:0] id_rs_data_i, id_rt_data_i, id_imm_i, id_pc4_i;
    logic [4:0]    id_rs_i, id_rt_i, id_rd_i;
    logic          flush_i, hold_i;

    logic          ex_valid_o;
    logic [17:0]   ex_ctrl_o;
    logic [4:0]    ex_shamt_o;
    logic [DW-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o;
    logic [4:0]    ex_rs_o, ex_rt_o, ex_rd_o;
    logic          stall_o;
    logic [15:0]   stall_cnt_o;

    logic          s_valid_o;
    logic [17:0]   s_ctrl_o;
    logic [4:0]    s_shamt_o;
    logic [DW-1:0] s_rs_data_o, s_rt_data_o, s_imm_o, s_pc4_o;
    logic [4:0]    s_rs_o, s_rt_o, s_rd_o;
    logic          s_stall_o;
    logic [1:0]    s_stall_cnt_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    id_ex_pipe #(.DATA_W(DW), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
        .id_shamt_i(id_shamt_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_imm_i(id_imm_i), .id_pc4_i(id_pc4_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rd_i(id_rd_i), .flush_i(flush_i), .hold_i(hold_i), .ex_valid_o(ex_valid_o),
        .ex_ctrl_o(ex_ctrl_o), .ex_shamt_o(ex_shamt_o), .ex_rs_data_o(ex_rs_data_o),
        .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o), .ex_pc4_o(ex_pc4_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .stall_o(stall_o),
        .stall_cnt_o(stall_cnt_o)
    );

    // Narrow-counter copy on the same stimulus exercises saturation quickly
    id_ex_pipe #(.DATA_W(DW), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
        .id_shamt_i(id_shamt_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
        .id_imm_i(id_imm_i), .id_pc4_i(id_pc4_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
        .id_rd_i(id_rd_i), .flush_i(flush_i), .hold_i(hold_i), .ex_valid_o(s_valid_o),
        .ex_ctrl_o(s_ctrl_o), .ex_shamt_o(s_shamt_o), .ex_rs_data_o(s_rs_data_o),
        .ex_rt_data_o(s_rt_data_o), .ex_imm_o(s_imm_o), .ex_pc4_o(s_pc4_o),
        .ex_rs_o(s_rs_o), .ex_rt_o(s_rt_o), .ex_rd_o(s_rd_o), .stall_o(s_stall_o),
        .stall_cnt_o(s_stall_cnt_o)
    );

    // Reference model: the instruction sitting in EX plus a stall tally
    logic          m_valid;
    logic [17:0]   m_ctrl;
    logic [4:0]    m_shamt;
    logic [DW-1:0] m_rs_data, m_rt_data, m_imm, m_pc4;
    logic [4:0]    m_rs, m_rt, m_rd;
    int unsigned   m_cnt;

    function automatic logic m_hazard();
        logic ex_load, rt_src;
        ex_load = m_valid && m_ctrl[15] && (m_rt != 5'd0);
        rt_src  = id_ctrl_i[9] || id_ctrl_i[14] || id_ctrl_i[13];
        return ex_load && id_valid_i && ((m_rt == id_rs_i) || ((m_rt == id_rt_i) && rt_src));
    endfunction

    function automatic logic m_stall();
        return m_hazard() && !flush_i && !hold_i;
    endfunction

    function automatic logic [166:0] m_state();
        return {m_valid, m_ctrl, m_shamt, m_rs_data, m_rt_data, m_imm, m_pc4, m_rs, m_rt, m_rd};
    endfunction

    function automatic logic [353:0] model_bus();
        logic [1:0] sc;
        sc = (m_cnt > 3) ? 2'd3 : m_cnt[1:0];
        return {m_state(), m_stall(), m_cnt[15:0], m_state(), m_stall(), sc};
    endfunction

    function automatic logic [353:0] dut_bus();
        return {ex_valid_o, ex_ctrl_o, ex_shamt_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
                ex_pc4_o, ex_rs_o, ex_rt_o, ex_rd_o, stall_o, stall_cnt_o,
                s_valid_o, s_ctrl_o, s_shamt_o, s_rs_data_o, s_rt_data_o, s_imm_o,
                s_pc4_o, s_rs_o, s_rt_o, s_rd_o, s_stall_o, s_stall_cnt_o};
    endfunction

    task automatic m_zero();
        m_valid = 1'b0; m_ctrl = '0; m_shamt = '0; m_rs_data = '0; m_rt_data = '0;
        m_imm = '0; m_pc4 = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    endtask

    // One clock: model follows flush > hold > hazard > capture, ends at negedge
    task automatic tick();
        logic hz, st;
        hz = m_hazard();
        st = m_stall();
        @(posedge clk_i);
        if (flush_i || (!hold_i && hz)) begin
            m_zero();
        end else if (!hold_i) begin
            m_valid = id_valid_i; m_ctrl = id_valid_i ? id_ctrl_i : 18'd0;
            m_shamt = id_shamt_i; m_rs_data = id_rs_data_i; m_rt_data = id_rt_data_i;
            m_imm = id_imm_i; m_pc4 = id_pc4_i; m_rs = id_rs_i; m_rt = id_rt_i; m_rd = id_rd_i;
        end
        if (st && m_cnt < 32'hFFFF) m_cnt = m_cnt + 1;
        @(negedge clk_i);
    endtask

    task automatic set_id(input logic v, input logic [17:0] c,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid_i = v; id_ctrl_i = c; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
        id_shamt_i = 5'($urandom); id_rs_data_i = $urandom; id_rt_data_i = $urandom;
        id_imm_i = $urandom; id_pc4_i = $urandom | 32'h4;
        flush_i = 1'b0; hold_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd3);
        m_zero(); m_cnt = 0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_vec++;
        if (dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL reset_state: got %h want %h", dut_bus(), model_bus());
        end
        rst_i = 1'b1;
        set_id(1'b1, C_ADDI, 5'd1, 5'd2, 5'd3);
        #1; tick();
        n_vec++;
        if (dut_bus() !== model_bus() || ex_valid_o !== 1'b1 || ex_rd_o !== 5'd3) begin
            n_err++; $display("FAIL first_capture: got %h want %h", dut_bus(), model_bus());
        end
    endtask

    task automatic test_load_use();
        set_id(1'b1, C_LW, 5'd29, 5'd8, 5'd0);
        #1; tick();
        set_id(1'b1, C_ADD, 5'd8, 5'd10, 5'd9);
        #1;
        n_vec++;
        if (stall_o !== 1'b1 || dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL lu_stall: stall %b want 1; got %h want %h", stall_o, dut_bus(), model_bus());
        end
        tick();
        n_vec++;
        if (ex_valid_o !== 1'b0 || stall_cnt_o !== 16'd1 || dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL lu_bubble: valid %b cnt %0d; got %h want %h", ex_valid_o, stall_cnt_o, dut_bus(), model_bus());
        end
        tick();
        n_vec++;
        if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd9 || ex_ctrl_o !== C_ADD || dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL lu_capture: got %h want %h", dut_bus(), model_bus());
        end
    endtask

    task automatic test_zero_dest();
        set_id(1'b1, C_LW, 5'd4, 5'd0, 5'd0);
        #1; tick();
        set_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd11);
        #1;
        n_vec++;
        if (stall_o !== 1'b0 || dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL zero_dest_stall: stall %b want 0; got %h want %h", stall_o, dut_bus(), model_bus());
        end
        tick();
        n_vec++;
        if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd11 || dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL zero_dest_capture: got %h want %h", dut_bus(), model_bus());
        end
    endtask

    task automatic test_flush_hazard();
        int unsigned cnt_before;
        set_id(1'b1, C_LW, 5'd2, 5'd5, 5'd0);
        #1; tick();
        set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7);
        flush_i = 1'b1;
        cnt_before = m_cnt;
        #1;
        n_vec++;
        if (stall_o !== 1'b0 || dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL flush_stall: stall %b want 0; got %h want %h", stall_o, dut_bus(), model_bus());
        end
        tick();
        n_vec++;
        if (ex_valid_o !== 1'b0 || stall_cnt_o !== cnt_before[15:0] || dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL flush_bubble: cnt %0d want %0d; got %h want %h", stall_cnt_o, cnt_before, dut_bus(), model_bus());
        end
    endtask

    task automatic test_hold();
        logic [166:0] held;
        int unsigned  cnt_before;
        set_id(1'b1, C_ADDI, 5'd3, 5'd4, 5'd0);
        #1; tick();
        held = m_state();
        cnt_before = m_cnt;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, C_ADD, 5'd4, 5'd4, 5'(i + 12));
            hold_i = 1'b1;
            #1; tick();
            n_vec++;
            if ({ex_valid_o, ex_ctrl_o, ex_shamt_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
                 ex_pc4_o, ex_rs_o, ex_rt_o, ex_rd_o} !== held ||
                stall_cnt_o !== cnt_before[15:0] || dut_bus() !== model_bus()) begin
                n_err++; $display("FAIL hold_%0d: got %h want %h", i, dut_bus(), model_bus());
            end
        end
        // hold over a live load-use: no stall, no count
        set_id(1'b1, C_LW, 5'd1, 5'd9, 5'd0);
        #1; tick();
        set_id(1'b1, C_ADD, 5'd9, 5'd1, 5'd2);
        hold_i = 1'b1;
        #1;
        n_vec++;
        if (stall_o !== 1'b0 || dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL hold_hazard: stall %b want 0; got %h want %h", stall_o, dut_bus(), model_bus());
        end
        tick();
    endtask

    task automatic test_saturation();
        int unsigned start;
        start = m_cnt;
        for (int i = 0; i < 4; i++) begin
            set_id(1'b1, C_LW, 5'd1, 5'd7, 5'd0);
            #1; tick();
            set_id(1'b1, C_ADD, 5'd2, 5'd7, 5'd3);
            #1; tick();
            n_vec++;
            if (dut_bus() !== model_bus()) begin
                n_err++; $display("FAIL sat_step_%0d: got %h want %h", i, dut_bus(), model_bus());
            end
        end
        n_vec++;
        if (s_stall_cnt_o !== 2'b11 || stall_cnt_o !== 16'(start + 4)) begin
            n_err++; $display("FAIL sat_final: narrow %b want 11, wide %0d want %0d", s_stall_cnt_o, stall_cnt_o, start + 4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            set_id(($urandom % 8) != 0, {16'($urandom), 2'b00},
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom));
            flush_i = ($urandom % 10) == 0;
            hold_i  = ($urandom % 6) == 0;
            #1;
            n_vec++;
            if (dut_bus() !== model_bus()) begin
                n_err++; $display("FAIL random_%0d: got %h want %h", i, dut_bus(), model_bus());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        set_id(1'b1, C_LW, 5'd17, 5'd18, 5'd19);
        #1; tick();
        set_id(1'b1, C_ADD, 5'd18, 5'd20, 5'd21);
        @(posedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        m_zero(); m_cnt = 0;
        n_vec++;
        if (dut_bus() !== model_bus()) begin
            n_err++; $display("FAIL async_reset: got %h want %h", dut_bus(), model_bus());
        end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_dest();
        test_flush_hazard();
        test_hold();
        test_saturation();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
